// File: rtl/uart_pkg.sv
// Shared UART definitions: default bus addresses, line timing and the TX/RX frame state encoding.
// The build option UART_TX_FIFO_EN (see uart_tx_ctrl) uses DEF_FIFO_DEPTH.
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ     = 50_000_000;
  localparam int unsigned DEF_BAUD       = 115200;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam logic [7:0] DEF_TX_DATA_ADDR = 8'd253;
  localparam logic [7:0] DEF_INT_ACK_ADDR = 8'd254;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Integer floor, so the real line rate is slightly above BAUD when the division is inexact.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmit shifter; DEPTH must be a power of two (>= 2).
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] w_data,
  input  logic       pop,
  output logic [7:0] r_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= w_data;
  end

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign r_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_ctrl.sv
// CPU-facing 8N1 UART transmitter with a sticky transmit-complete interrupt and overrun flag.
// Define UART_TX_FIFO_EN to queue writes in a FIFO_DEPTH-entry FIFO ahead of the shifter.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned BAUD         = DEF_BAUD,
  parameter logic [7:0]  TX_DATA_ADDR = DEF_TX_DATA_ADDR,
  parameter logic [7:0]  INT_ACK_ADDR = DEF_INT_ACK_ADDR
`ifdef UART_TX_FIFO_EN
  , parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] access_addr,
  input  logic       reg_w_en,
  input  logic [7:0] w_data,
  output logic       tx,
  output logic       busy_flag,
  output logic       int_req,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shifter, shifter_next;
  logic             tx_next;
  logic             frame_load;
  logic             int_set;

  logic             data_wr;
  logic             accept;
  logic             ack;
  logic             idle_avail;
  logic [7:0]       idle_byte;
  logic             chain_avail;
  logic [7:0]       chain_byte;

  assign data_wr = reg_w_en && (access_addr == TX_DATA_ADDR);
  assign ack     = reg_w_en && (access_addr == INT_ACK_ADDR);
  assign accept  = data_wr && !busy_flag;

`ifdef UART_TX_FIFO_EN
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;

  // A write into an empty FIFO while idle bypasses it so the start bit still follows on the next edge.
  assign busy_flag   = fifo_full;
  assign idle_avail  = !fifo_empty || accept;
  assign idle_byte   = fifo_empty ? w_data : fifo_rd_data;
  assign chain_avail = !fifo_empty;
  assign chain_byte  = fifo_rd_data;
  assign fifo_pop    = frame_load && !fifo_empty;
  assign fifo_push   = accept && !((state == IDLE) && fifo_empty);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .w_data (w_data),
    .pop    (fifo_pop),
    .r_data (fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
`else
  assign busy_flag   = (state != IDLE);
  assign idle_avail  = accept;
  assign idle_byte   = w_data;
  assign chain_avail = 1'b0;
  assign chain_byte  = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shifter  <= shifter_next;
      tx       <= tx_next;
    end
  end

  // The baud counter restarts on every state entry; tx is driven from the next state so it stays registered.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    shifter_next  = shifter;
    frame_load    = 1'b0;
    int_set       = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (idle_avail) begin
          state_next   = START;
          shifter_next = idle_byte;
          frame_load   = 1'b1;
        end
      end
      START: begin
        if (baud_cnt == CNT_LAST) begin
          state_next    = DATA;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
        end
      end
      DATA: begin
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_next = '0;
          shifter_next  = {1'b0, shifter[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_next = '0;
          if (chain_avail) begin
            state_next   = START;
            shifter_next = chain_byte;
            frame_load   = 1'b1;
          end else begin
            state_next = IDLE;
            int_set    = 1'b1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shifter_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Setting beats an acknowledge arriving in the same cycle, for both sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (int_set)  int_req <= 1'b1;
      else if (ack) int_req <= 1'b0;

      if (data_wr && busy_flag) overrun <= 1'b1;
      else if (ack)             overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level reference model predicts the line and the flags.
// Follows UART_TX_FIFO_EN so the same bench covers both builds.
module tb_uart_tx_ctrl;

  localparam int CPB   = 50_000_000 / 115200;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] access_addr;
  logic       reg_w_en;
  logic [7:0] w_data;
  logic       tx;
  logic       busy_flag;
  logic       int_req;
  logic       overrun;

  uart_tx_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .access_addr (access_addr),
    .reg_w_en    (reg_w_en),
    .w_data      (w_data),
    .tx          (tx),
    .busy_flag   (busy_flag),
    .int_req     (int_req),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         m_active = 1'b0;
  int         m_fs     = 0;
  logic [7:0] m_byte   = 8'h00;
  logic [7:0] m_q[$];
  bit         m_int    = 1'b0;
  bit         m_ovr    = 1'b0;
  bit         m_evt    = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    int b;
    if (!m_active) return 1'b1;
    k = cyc - m_fs;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    if (FIFO_EN) return (m_q.size() == DEPTH);
    return m_active;
  endfunction

  // Frame-level model: a frame is a start time plus a byte; queued bytes wait for the line to free up.
  always @(posedge clk or negedge rst_n) begin : model
    bit wr, ack, busy_pre, acc, ending, took, iset;
    if (!rst_n) begin
      m_active = 1'b0;
      m_q.delete();
      m_int = 1'b0;
      m_ovr = 1'b0;
      m_evt = 1'b0;
    end else begin
      cyc++;
      wr       = reg_w_en && (access_addr == 8'd253);
      ack      = reg_w_en && (access_addr == 8'd254);
      busy_pre = exp_busy();
      acc      = wr && !busy_pre;
      ending   = m_active && ((cyc - m_fs) == FRAME);
      took     = 1'b0;
      iset     = 1'b0;
      if (ending) begin
        if (FIFO_EN && m_q.size() > 0) begin
          m_byte = m_q.pop_front();
          m_fs   = cyc;
        end else begin
          m_active = 1'b0;
          iset     = 1'b1;
        end
      end else if (!m_active) begin
        if (m_q.size() > 0) begin
          m_byte   = m_q.pop_front();
          m_fs     = cyc;
          m_active = 1'b1;
        end else if (acc) begin
          m_byte   = w_data;
          m_fs     = cyc;
          m_active = 1'b1;
          took     = 1'b1;
        end
      end
      if (acc && !took) m_q.push_back(w_data);
      if (iset)     m_int = 1'b1;
      else if (ack) m_int = 1'b0;
      if (wr && busy_pre) m_ovr = 1'b1;
      else if (ack)       m_ovr = 1'b0;
      m_evt = reg_w_en;
    end
  end

  always @(negedge clk) begin : sampler
    int r;
    r = m_active ? ((cyc - m_fs) % CPB) : 0;
    if (!m_active || r == 0 || r == 1 || r == CPB / 2 || r == CPB - 1 || m_evt) begin
      checkOutput("tx", tx, exp_tx());
      checkOutput("busy_flag", busy_flag, exp_busy());
      checkOutput("int_req", int_req, m_int);
      checkOutput("overrun", overrun, m_ovr);
    end
  end

  // Called on a falling edge; holds the strobe for exactly one cycle.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    access_addr = addr;
    w_data      = data;
    reg_w_en    = 1'b1;
    @(negedge clk);
    reg_w_en    = 1'b0;
    access_addr = 8'($urandom);
    w_data      = 8'($urandom);
  endtask

  task automatic waitUntil(input int target);
    for (int i = 0; i < 60000 && cyc < target; i++) @(negedge clk);
    if (cyc < target) checkOutput("wait_until_timeout", 32'(cyc), 32'(target));
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 7 * FRAME; i++) begin
      if (!m_active && m_q.size() == 0 && !busy_flag) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("idle_wait", done, 1'b1);
  endtask

  initial begin : stim
    int         c0;
    logic [9:0] a5_frame;
    rst_n       = 1'b0;
    reg_w_en    = 1'b0;
    access_addr = 8'h00;
    w_data      = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy_flag, 1'b0);
    checkOutput("reset_int", int_req, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] writes to unrelated addresses");
    applyStimulus(8'd252, 8'h00);
    applyStimulus(8'd255, 8'hFF);
    applyStimulus(8'd252, 8'h5A);
    repeat (3) @(negedge clk);
    checkOutput("other_addr_tx", tx, 1'b1);
    checkOutput("other_addr_busy", busy_flag, 1'b0);
    checkOutput("other_addr_int", int_req, 1'b0);

    $display("[TB] single frame 8'hA5");
    a5_frame = {1'b1, 8'hA5, 1'b0};
    c0 = cyc;
    applyStimulus(8'd253, 8'hA5);
    checkOutput("a5_start_edge", tx, 1'b0);
    for (int b = 0; b < 10; b++) begin
      waitUntil(c0 + 1 + b * CPB + CPB / 2);
      checkOutput("a5_bit", tx, a5_frame[b]);
    end
    waitUntil(c0 + FRAME);
    checkOutput("a5_int_before", int_req, 1'b0);
    waitUntil(c0 + FRAME + 1);
    checkOutput("a5_int_set", int_req, 1'b1);
    applyStimulus(8'd254, 8'h00);
    checkOutput("a5_ack", int_req, 1'b0);

    $display("[TB] write while busy");
    applyStimulus(8'd253, 8'h55);
    repeat (99) @(negedge clk);
    applyStimulus(8'd253, 8'h0F);
    checkOutput("busy_overrun", overrun, !FIFO_EN);
    checkOutput("busy_flag_held", busy_flag, !FIFO_EN);
    waitIdle();
    applyStimulus(8'd254, 8'h00);

    $display("[TB] back-to-back writes");
    for (int i = 1; i <= 6; i++) applyStimulus(8'd253, 8'(i));
    checkOutput("burst_overrun", overrun, 1'b1);
    waitIdle();
    checkOutput("burst_int", int_req, 1'b1);
    applyStimulus(8'd254, 8'h00);

    $display("[TB] acknowledge collides with interrupt set");
    c0 = cyc;
    applyStimulus(8'd253, 8'($urandom));
    waitUntil(c0 + FRAME);
    applyStimulus(8'd254, 8'h00);
    checkOutput("set_wins", int_req, 1'b1);

    $display("[TB] reset during data bit 3");
    c0 = cyc;
    applyStimulus(8'd253, 8'h3C);
    repeat (50) @(negedge clk);
    applyStimulus(8'd253, 8'h77);
    waitUntil(c0 + 1 + 4 * CPB + CPB / 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tx", tx, 1'b1);
    checkOutput("midrst_busy", busy_flag, 1'b0);
    checkOutput("midrst_int", int_req, 1'b0);
    checkOutput("midrst_ovr", overrun, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'd253, 8'hFF);
    waitIdle();
    checkOutput("post_rst_int", int_req, 1'b1);
    applyStimulus(8'd254, 8'h00);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 6; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5)      applyStimulus(8'd253, 8'($urandom));
      else if (op <= 7) applyStimulus(8'($urandom_range(0, 252)), 8'($urandom));
      else              applyStimulus(8'd254, 8'($urandom));
      repeat ($urandom_range(1, 1200)) @(negedge clk);
    end
    waitIdle();
    applyStimulus(8'd254, 8'h00);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
